// File: rtl/dec_unbinder_seq.sv
// dec_unbinder_seq: sequential unbinder/decoder for sparse HDC queries.
// For each channel in turn, the latched query is rotated right by that
// channel's shift, which undoes the encoder's left-rotate binding. The unbound
// vector is then scored against every level hypervector by AND-popcount
// overlap, one level per cycle, and the best-matching level index is kept.
//
// Ports:
//   clk            rising-edge system clock
//   nrst           synchronous active-high reset
//   start_decoding decode request, sampled only in IDLE
//   query_hv       bound query hypervector, latched on the accepted start
//   level_hv       level item memory, held stable by the caller while busy
//   decoded_level  best level index per channel
//   no_match       bit ch set when every score for channel ch was zero
//   busy           decode in progress
//   done           one-cycle pulse once every channel is committed
//   results_valid  decoded_level/no_match valid until the next accepted start
module dec_unbinder_seq #(
    parameter int unsigned HV_DIM     = 1024,
    parameter int unsigned NUM_CH     = 10,
    parameter int unsigned NUM_LEVELS = 16,
    parameter int unsigned CH_BASE    = 0
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          start_decoding,
    input  logic [HV_DIM-1:0]             query_hv,
    input  logic [HV_DIM-1:0]             level_hv      [0:NUM_LEVELS-1],
    output logic [$clog2(NUM_LEVELS)-1:0] decoded_level [0:NUM_CH-1],
    output logic [NUM_CH-1:0]             no_match,
    output logic                          busy,
    output logic                          done,
    output logic                          results_valid
);

    localparam int unsigned LV_W = $clog2(NUM_LEVELS);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned SH_W = (HV_DIM > 1) ? $clog2(HV_DIM) : 1;
    localparam int unsigned SC_W = $clog2(HV_DIM + 1);

    // Shift table shared by every decoder instance; CH_BASE selects the slice
    // that belongs to this instance.
    localparam int unsigned SHIFT_TAB_LEN = 16;
    localparam int unsigned SHIFT_TAB [SHIFT_TAB_LEN] = '{
        5, 17, 0, 63, 101, 230, 347, 512, 777, 1023, 11, 29, 64, 1024, 389, 901
    };

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNBIND,
        S_SCORE,
        S_COMMIT,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [HV_DIM-1:0]   r_query;
    logic [HV_DIM-1:0]   r_unbound;
    logic [CH_W-1:0]     r_ch;
    logic [LV_W-1:0]     r_lvl;
    logic [SC_W-1:0]     r_best_score;
    logic [LV_W-1:0]     r_best_idx;
    logic                r_any_hit;

    logic [SH_W-1:0]     w_ch_shift [NUM_CH];
    logic [SH_W-1:0]     w_shift;
    logic [HV_DIM-1:0]   w_rot;
    logic [SC_W-1:0]     w_score;

    // Per-channel rotate amount, reduced mod HV_DIM so any table entry is legal.
    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_shift
        assign w_ch_shift[g] = SH_W'(SHIFT_TAB[CH_BASE + g] % HV_DIM);
    end

    assign w_shift = w_ch_shift[r_ch];

    // Rotate right: bit i of the result is query[(i + S) mod HV_DIM].
    assign w_rot = HV_DIM'({r_query, r_query} >> w_shift);

    function automatic logic [SC_W-1:0] popcount(input logic [HV_DIM-1:0] v);
        logic [SC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(HV_DIM); i++) begin
            cnt = cnt + SC_W'(v[i]);
        end
        return cnt;
    endfunction

    assign w_score = popcount(r_unbound & level_hv[r_lvl]);

    // Decode sequencer: one channel per UNBIND/SCORE*/COMMIT pass.
    always_ff @(posedge clk) begin
        if (nrst) begin
            r_state       <= S_IDLE;
            r_query       <= '0;
            r_unbound     <= '0;
            r_ch          <= '0;
            r_lvl         <= '0;
            r_best_score  <= '0;
            r_best_idx    <= '0;
            r_any_hit     <= 1'b0;
            for (int c = 0; c < int'(NUM_CH); c++) begin
                decoded_level[c] <= '0;
            end
            no_match      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            results_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_decoding) begin
                        r_query       <= query_hv;
                        r_ch          <= '0;
                        results_valid <= 1'b0;
                        busy          <= 1'b1;
                        r_state       <= S_UNBIND;
                    end
                end

                S_UNBIND: begin
                    r_unbound    <= w_rot;
                    r_lvl        <= '0;
                    r_best_score <= '0;
                    r_best_idx   <= '0;
                    r_any_hit    <= 1'b0;
                    r_state      <= S_SCORE;
                end

                S_SCORE: begin
                    // Strict compare keeps the lowest index on ties.
                    if (w_score > r_best_score) begin
                        r_best_score <= w_score;
                        r_best_idx   <= r_lvl;
                    end
                    if (w_score != '0) begin
                        r_any_hit <= 1'b1;
                    end
                    if (r_lvl == LV_W'(NUM_LEVELS - 1)) begin
                        r_state <= S_COMMIT;
                    end else begin
                        r_lvl <= r_lvl + 1'b1;
                    end
                end

                S_COMMIT: begin
                    decoded_level[r_ch] <= r_best_idx;
                    no_match[r_ch]      <= ~r_any_hit;
                    if (r_ch == CH_W'(NUM_CH - 1)) begin
                        busy    <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_ch    <= r_ch + 1'b1;
                        r_state <= S_UNBIND;
                    end
                end

                S_DONE: begin
                    done          <= 1'b1;
                    busy          <= 1'b0;
                    results_valid <= 1'b1;
                    r_state       <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
